// File: rtl/uv_uart_pkg.sv
// uv_uart_pkg -- definitions shared by the UART transmitter and receiver.
//   uart_state_e    : frame FSM states (IDLE 0 .. STOP1 5)
//   PAR_*           : parity_type codes
//   DATA_W_OFFSET   : data bits = nbits + DATA_W_OFFSET
//   data_bits()     : nbits field -> number of data bits (5..8)
//   parity_expected : value the parity bit must carry for a given mode
package uv_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP0  = 3'd4,
        ST_STOP1  = 3'd5
    } uart_state_e;

    localparam logic [1:0] PAR_SPACE = 2'b00;
    localparam logic [1:0] PAR_MARK  = 2'b01;
    localparam logic [1:0] PAR_ODD   = 2'b10;
    localparam logic [1:0] PAR_EVEN  = 2'b11;

    localparam int DATA_W_OFFSET = 5;

    function automatic logic [3:0] data_bits(input logic [1:0] nbits);
        return {2'b00, nbits} + 4'(DATA_W_OFFSET);
    endfunction

    // acc is the XOR of all received data bits.
    function automatic logic parity_expected(input logic [1:0] ptype, input logic acc);
        case (ptype)
            PAR_SPACE: return 1'b0;
            PAR_MARK:  return 1'b1;
            PAR_ODD:   return ~acc;
            default:   return acc;
        endcase
    endfunction

endpackage

// File: rtl/uv_sync_2ff.sv
// uv_sync_2ff -- two-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; both flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronized output (two clk cycles of latency)
module uv_sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= {2{RST_VAL}};
        end else begin
            sync_reg <= {sync_reg[0], d};
        end
    end

    assign q = sync_reg[1];

endmodule

// File: rtl/uv_uart_rx.sv
// uv_uart_rx -- UART receiver with configurable frame format.
//   clk, rst_n    : clock, asynchronous active-low reset
//   uart_rx       : asynchronous serial input, idle high
//   rx_en         : receiver enable; low aborts any frame in progress
//   nbits         : data bits = nbits + 5
//   nstop         : 0 one stop bit, 1 two stop bits
//   endian        : 0 first bit -> rx_dat[0], 1 first bit -> rx_dat[n-1]
//   clk_div       : clk cycles per bit (>= 4)
//   parity_en     : parity bit present after the data bits
//   parity_type   : 00 space, 01 mark, 10 odd, 11 even
//   rx_rdy        : sink can accept a word (sampled in the delivery cycle)
//   rx_vld        : one-cycle push strobe carrying rx_dat/rx_perr/rx_ferr
//   rx_dat        : received character, zero-extended
//   rx_perr       : parity error for the delivered word
//   rx_ferr       : framing error (stop bit sampled low)
//   rx_ovf        : one-cycle pulse, word dropped because rx_rdy was low
module uv_uart_rx
    import uv_uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    input  logic        rx_en,
    input  logic [1:0]  nbits,
    input  logic        nstop,
    input  logic        endian,
    input  logic [15:0] clk_div,
    input  logic        parity_en,
    input  logic [1:0]  parity_type,
    input  logic        rx_rdy,
    output logic        rx_vld,
    output logic [7:0]  rx_dat,
    output logic        rx_perr,
    output logic        rx_ferr,
    output logic        rx_ovf
);

    logic        rx_s;
    logic        rx_s_d_reg;
    uart_state_e state_reg, state_next;
    logic [15:0] clk_cnt_reg;
    logic [15:0] clk_cnt_inc;
    logic        cnt_end, cnt_half;
    logic [2:0]  bit_cnt_reg;
    logic        last_bit;
    logic [7:0]  shift_reg;
    logic        acc_reg, perr_reg;
    logic        sample_data, sample_par, deliver;
    logic [3:0]  n_bits;
    logic [7:0]  shift_rev, word, word_rev, rx_dat_next;
    logic        rx_vld_reg, rx_ovf_reg, rx_perr_reg, rx_ferr_reg;
    logic [7:0]  rx_dat_reg;

    uv_sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uart_rx),
        .q     (rx_s)
    );

    // 16-bit increment wraps, so even a nonsensical clk_div change
    // mid-frame eventually produces cnt_end and the FSM cannot hang.
    assign clk_cnt_inc = clk_cnt_reg + 16'd1;
    assign cnt_end     = (clk_cnt_inc == clk_div);
    assign cnt_half    = (clk_cnt_inc == {1'b0, clk_div[15:1]});
    assign last_bit    = (bit_cnt_reg == ({1'b0, nbits} + 3'd4));
    assign n_bits      = data_bits(nbits);

    // Bits enter at the MSB, so after n shifts the first bit sits at 8-n.
    // Full reversal puts the first bit at n-1; the mask drops the stale
    // low bits of the shifter that the reversal moved above n-1.
    for (genvar gi = 0; gi < 8; gi++) begin : g_rev
        assign shift_rev[gi] = shift_reg[7-gi];
    end
    assign word        = shift_reg >> (4'd8 - n_bits);
    assign word_rev    = shift_rev & (8'hFF >> (4'd8 - n_bits));
    assign rx_dat_next = endian ? word_rev : word;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (!rx_en) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:   if (!rx_s && rx_s_d_reg) state_next = ST_START;
                ST_START: begin
                    if (cnt_half && rx_s)  state_next = ST_IDLE;   // glitch
                    else if (cnt_end)      state_next = ST_DATA;
                end
                ST_DATA:   if (cnt_end && last_bit)
                               state_next = parity_en ? ST_PARITY : ST_STOP0;
                ST_PARITY: if (cnt_end) state_next = ST_STOP0;
                // Leaving at mid-stop leaves half a bit to catch the next
                // start edge of a back-to-back frame.
                ST_STOP0: begin
                    if (cnt_half && !nstop) state_next = ST_IDLE;
                    else if (cnt_end)       state_next = ST_STOP1;
                end
                ST_STOP1:  if (cnt_half) state_next = ST_IDLE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    // Output / control decode
    always_comb begin
        sample_data = 1'b0;
        sample_par  = 1'b0;
        deliver     = 1'b0;
        case (state_reg)
            ST_DATA:   sample_data = cnt_half;
            ST_PARITY: sample_par  = cnt_half;
            ST_STOP0:  deliver     = cnt_half & rx_en;
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s_d_reg  <= 1'b1;
            clk_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            acc_reg     <= 1'b0;
            perr_reg    <= 1'b0;
            rx_vld_reg  <= 1'b0;
            rx_ovf_reg  <= 1'b0;
            rx_dat_reg  <= '0;
            rx_perr_reg <= 1'b0;
            rx_ferr_reg <= 1'b0;
        end else begin
            rx_s_d_reg <= rx_s;

            if (state_reg == ST_IDLE || cnt_end) begin
                clk_cnt_reg <= '0;
            end else begin
                clk_cnt_reg <= clk_cnt_inc;
            end

            if (state_reg == ST_START) begin
                bit_cnt_reg <= '0;
            end else if (state_reg == ST_DATA && cnt_end) begin
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end

            if (state_reg == ST_IDLE) begin
                acc_reg  <= 1'b0;
                perr_reg <= 1'b0;
            end
            if (sample_data) begin
                shift_reg <= {rx_s, shift_reg[7:1]};
                acc_reg   <= acc_reg ^ rx_s;
            end
            if (sample_par) begin
                perr_reg <= (rx_s != parity_expected(parity_type, acc_reg));
            end

            rx_vld_reg <= deliver & rx_rdy;
            rx_ovf_reg <= deliver & ~rx_rdy;
            if (deliver && rx_rdy) begin
                rx_dat_reg  <= rx_dat_next;
                rx_perr_reg <= parity_en & perr_reg;
                rx_ferr_reg <= ~rx_s;
            end
        end
    end

    assign rx_vld  = rx_vld_reg;
    assign rx_ovf  = rx_ovf_reg;
    assign rx_dat  = rx_dat_reg;
    assign rx_perr = rx_perr_reg;
    assign rx_ferr = rx_ferr_reg;

endmodule

// File: tb/tb_uv_uart_rx.sv
// tb_uv_uart_rx -- directed bench for uv_uart_rx.
module tb_uv_uart_rx;
    import uv_uart_pkg::*;

    localparam int DIV = 16;
    // pin falling edge -> rx_vld: 3 (sync + edge detect) + DIV/2 + 9 bits * DIV
    localparam int LAT9 = 3 + DIV / 2 + 9 * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        rx_en = 1'b0;
    logic [1:0]  nbits = 2'd3;
    logic        nstop = 1'b0;
    logic        endian = 1'b0;
    logic [15:0] clk_div = 16'(DIV);
    logic        parity_en = 1'b0;
    logic [1:0]  parity_type = 2'b00;
    logic        rx_rdy = 1'b1;
    logic        rx_vld, rx_perr, rx_ferr, rx_ovf;
    logic [7:0]  rx_dat;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vld_cnt = 0;
    int ovf_cnt = 0;
    int vld_cyc = 0;
    logic [7:0] recv [0:15];
    logic last_perr = 1'b0;
    logic last_ferr = 1'b0;

    uv_uart_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .uart_rx     (uart_rx),
        .rx_en       (rx_en),
        .nbits       (nbits),
        .nstop       (nstop),
        .endian      (endian),
        .clk_div     (clk_div),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .rx_rdy      (rx_rdy),
        .rx_vld      (rx_vld),
        .rx_dat      (rx_dat),
        .rx_perr     (rx_perr),
        .rx_ferr     (rx_ferr),
        .rx_ovf      (rx_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_vld) begin
            recv[vld_cnt[3:0]] <= rx_dat;
            vld_cnt   <= vld_cnt + 1;
            vld_cyc   <= cyc;
            last_perr <= rx_perr;
            last_ferr <= rx_ferr;
            $display("rx word %02h perr %0d ferr %0d at cycle %0d", rx_dat, rx_perr, rx_ferr, cyc);
        end
        if (rx_ovf) begin
            ovf_cnt <= ovf_cnt + 1;
            $display("rx overflow at cycle %0d", cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge ending the last stop bit.
    // data[0] is the first transmitted data bit.
    task automatic send_frame(input logic [7:0] data, input int n, input logic par_en,
                              input logic par_bit, input int nst, input logic stop_val,
                              output int t0);
        uart_rx = 1'b0;
        t0 = cyc;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            uart_rx = data[i];
            repeat (DIV) @(negedge clk);
        end
        if (par_en) begin
            uart_rx = par_bit;
            repeat (DIV) @(negedge clk);
        end
        for (int s = 0; s < nst; s++) begin
            uart_rx = stop_val;
            repeat (DIV) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    initial begin
        int t0, v0, v1, o0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_vld", rx_vld, 0);
        check("rst_dat", rx_dat, 0);
        check("rst_perr", rx_perr, 0);
        check("rst_ferr", rx_ferr, 0);
        check("rst_ovf", rx_ovf, 0);
        check("rst_state", 32'(dut.state_reg), 32'(ST_IDLE));
        rst_n = 1'b1;
        rx_en = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1, 0xA5 LSB first
        v0 = vld_cnt;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, t0);
        repeat (8) @(negedge clk);
        check("a5_count", vld_cnt - v0, 1);
        check("a5_dat", recv[v0[3:0]], 8'hA5);
        check("a5_perr", last_perr, 0);
        check("a5_ferr", last_ferr, 0);
        check("a5_latency", vld_cyc - t0, LAT9);
        check("a5_vld_low", rx_vld, 0);
        check("a5_dat_hold", rx_dat, 8'hA5);

        // 7 data bits, even parity, 2 stop, endian 1: 1011001 then parity 0
        nbits = 2'd2; parity_en = 1'b1; parity_type = PAR_EVEN; nstop = 1'b1; endian = 1'b1;
        repeat (2) @(negedge clk);
        v0 = vld_cnt;
        send_frame(8'h4D, 7, 1'b1, 1'b0, 2, 1'b1, t0);
        repeat (8) @(negedge clk);
        check("e7_count", vld_cnt - v0, 1);
        check("e7_dat", recv[v0[3:0]], 8'h59);
        check("e7_perr", last_perr, 0);
        check("e7_ferr", last_ferr, 0);
        check("e7_latency", vld_cyc - t0, LAT9);

        // same with parity bit 1 -> parity error
        v0 = vld_cnt;
        send_frame(8'h4D, 7, 1'b1, 1'b1, 2, 1'b1, t0);
        repeat (8) @(negedge clk);
        check("e7b_count", vld_cnt - v0, 1);
        check("e7b_dat", recv[v0[3:0]], 8'h59);
        check("e7b_perr", last_perr, 1);

        // 8N1 with stop bit low -> framing error
        nbits = 2'd3; parity_en = 1'b0; parity_type = PAR_SPACE; nstop = 1'b0; endian = 1'b0;
        repeat (2) @(negedge clk);
        v0 = vld_cnt;
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b0, t0);
        repeat (8) @(negedge clk);
        check("fe_count", vld_cnt - v0, 1);
        check("fe_dat", recv[v0[3:0]], 8'h3C);
        check("fe_ferr", last_ferr, 1);
        check("fe_perr", last_perr, 0);

        // low glitch of DIV/4 cycles: START entered, then rejected
        v0 = vld_cnt; o0 = ovf_cnt;
        uart_rx = 1'b0;
        repeat (DIV / 4) @(negedge clk);
        uart_rx = 1'b1;
        check("gl_start", 32'(dut.state_reg), 32'(ST_START));
        repeat (30) @(negedge clk);
        check("gl_idle", 32'(dut.state_reg), 32'(ST_IDLE));
        repeat (200) @(negedge clk);
        check("gl_no_vld", vld_cnt - v0, 0);
        check("gl_no_ovf", ovf_cnt - o0, 0);

        // back-to-back frames
        v0 = vld_cnt; v1 = v0 + 1;
        send_frame(8'h12, 8, 1'b0, 1'b0, 1, 1'b1, t0);
        send_frame(8'hEF, 8, 1'b0, 1'b0, 1, 1'b1, t0);
        repeat (8) @(negedge clk);
        check("b2b_count", vld_cnt - v0, 2);
        check("b2b_dat0", recv[v0[3:0]], 8'h12);
        check("b2b_dat1", recv[v1[3:0]], 8'hEF);
        check("b2b_latency", vld_cyc - t0, LAT9);

        // second frame with rx_rdy low -> overflow
        v0 = vld_cnt; o0 = ovf_cnt;
        send_frame(8'h55, 8, 1'b0, 1'b0, 1, 1'b1, t0);
        repeat (4) @(negedge clk);
        rx_rdy = 1'b0;
        send_frame(8'h66, 8, 1'b0, 1'b0, 1, 1'b1, t0);
        repeat (8) @(negedge clk);
        rx_rdy = 1'b1;
        check("ovf_vld_count", vld_cnt - v0, 1);
        check("ovf_count", ovf_cnt - o0, 1);
        check("ovf_dat_hold", rx_dat, 8'h55);

        // rx_en dropped in DATA
        v0 = vld_cnt; o0 = ovf_cnt;
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        uart_rx = 1'b1; repeat (DIV) @(negedge clk);
        uart_rx = 1'b0; repeat (DIV) @(negedge clk);
        uart_rx = 1'b1; repeat (DIV) @(negedge clk);
        check("en_in_data", 32'(dut.state_reg), 32'(ST_DATA));
        rx_en = 1'b0;
        @(negedge clk);
        check("en_idle", 32'(dut.state_reg), 32'(ST_IDLE));
        repeat (200) @(negedge clk);
        rx_en = 1'b1;
        repeat (4) @(negedge clk);
        check("en_no_vld", vld_cnt - v0, 0);
        check("en_no_ovf", ovf_cnt - o0, 0);

        // asynchronous reset mid-frame
        uart_rx = 1'b0;
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_dat", rx_dat, 0);
        check("ar_vld", rx_vld, 0);
        check("ar_perr", rx_perr, 0);
        check("ar_ferr", rx_ferr, 0);
        check("ar_ovf", rx_ovf, 0);
        check("ar_state", 32'(dut.state_reg), 32'(ST_IDLE));
        uart_rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        v0 = vld_cnt;
        send_frame(8'h81, 8, 1'b0, 1'b0, 1, 1'b1, t0);
        repeat (8) @(negedge clk);
        check("ar_next_count", vld_cnt - v0, 1);
        check("ar_next_dat", recv[v0[3:0]], 8'h81);
        check("ar_next_ferr", last_ferr, 0);
        check("ar_next_latency", vld_cyc - t0, LAT9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
